conv_pe_array: RTL and testbench

Seven-row, 3x3 convolution compute stage that sits directly downstream of the input buffer. It captures the tagged kernel-row and bias words from the `data` bus into a local kernel register set. It then turns every valid 7-row pixel column (`pe_1`..`pe_7`) into five biased 3x3 dot products, one per centre row 2..6. Results leave through a 2-stage pipeline toward the partial-sum/output buffer.

---
 rtl/conv_pe_array.sv | 124 ++++++++++++
 tb/tb_conv_pe_array.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/conv_pe_array.sv
// conv_pe_array: 7-row 3x3 conv stage, five biased dot products per column; define PE_RELU_EN to clamp negative results to 0
module conv_pe_array #(
  parameter int PIX_W = 8,
  parameter int WGT_W = 8,
  parameter int OUT_W = 22
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [25:0]             data,
  input  logic                    data_valid,
  input  logic [3*PIX_W-1:0]      pe_1,
  input  logic [3*PIX_W-1:0]      pe_2,
  input  logic [3*PIX_W-1:0]      pe_3,
  input  logic [3*PIX_W-1:0]      pe_4,
  input  logic [3*PIX_W-1:0]      pe_5,
  input  logic [3*PIX_W-1:0]      pe_6,
  input  logic [3*PIX_W-1:0]      pe_7,
  input  logic                    pe_valid,
  input  logic                    conv_done,
  output logic signed [OUT_W-1:0] out_0,
  output logic signed [OUT_W-1:0] out_1,
  output logic signed [OUT_W-1:0] out_2,
  output logic signed [OUT_W-1:0] out_3,
  output logic signed [OUT_W-1:0] out_4,
  output logic                    out_valid,
  output logic                    kernel_ready,
  output logic                    drop_err
);
  localparam int PW = PIX_W + WGT_W + 1;
  typedef enum logic [2:0] {W_ROW0, W_ROW1, W_ROW2, W_BIAS, READY} state_t;
  state_t state, nxt;
  logic wk, wb, we0, we1, we2, bwe, fire, v1;
  logic signed [WGT_W-1:0] w [3][3];
  logic signed [WGT_W-1:0] bias, b1;
  logic [3*PIX_W-1:0] pe [7];
  logic signed [PW-1:0] p1 [5][9];
  logic signed [OUT_W-1:0] s [5];
  logic signed [OUT_W-1:0] o [5];
  assign pe[0] = pe_1;
  assign pe[1] = pe_2;
  assign pe[2] = pe_3;
  assign pe[3] = pe_4;
  assign pe[4] = pe_5;
  assign pe[5] = pe_6;
  assign pe[6] = pe_7;
  assign wk = data_valid && data[25:24] == 2'b00;
  assign wb = data_valid && data[25:24] == 2'b01;
  always_ff @(posedge clk)
    if (!rstn) state <= W_ROW0;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (conv_done) nxt = wk ? W_ROW1 : W_ROW0;
    else
      case (state)
        W_ROW0: nxt = wk ? W_ROW1 : W_ROW0;
        W_ROW1: nxt = wk ? W_ROW2 : W_ROW1;
        W_ROW2: nxt = wk ? W_BIAS : W_ROW2;
        W_BIAS: nxt = wb ? READY : W_BIAS;
        READY:  nxt = wk ? W_ROW1 : READY;
        default: nxt = W_ROW0;
      endcase
  end
  // conv_done restarts the set, so a same-cycle kernel word always lands in row 0
  always_comb begin
    we0  = wk && (conv_done || state == W_ROW0 || state == READY);
    we1  = wk && !conv_done && state == W_ROW1;
    we2  = wk && !conv_done && (state == W_ROW2 || state == W_BIAS);
    bwe  = wb && !conv_done && state == W_BIAS;
    fire = pe_valid && state == READY;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      w <= '{default: '0};
      bias <= '0;
      kernel_ready <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (we0) w[0][c] <= data[(3-c)*WGT_W-1 -: WGT_W];
        if (we1) w[1][c] <= data[(3-c)*WGT_W-1 -: WGT_W];
        if (we2) w[2][c] <= data[(3-c)*WGT_W-1 -: WGT_W];
      end
      if (bwe) bias <= data[WGT_W-1:0];
      kernel_ready <= nxt == READY;
      drop_err <= drop_err | (pe_valid && state != READY);
    end
  always_ff @(posedge clk)
    if (!rstn) v1 <= 1'b0;
    else v1 <= fire;
  // products use the kernel registers as they stand when the column is sampled
  always_ff @(posedge clk)
    if (fire) begin
      b1 <= bias;
      for (int j = 0; j < 5; j++)
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            p1[j][r*3+c] <= PW'($signed({1'b0, pe[j+r][(3-c)*PIX_W-1 -: PIX_W]})) * PW'(w[r][c]);
    end
  always_comb
    for (int j = 0; j < 5; j++) begin
      s[j] = OUT_W'(b1);
      for (int k = 0; k < 9; k++) s[j] = s[j] + OUT_W'(p1[j][k]);
    end
  always_ff @(posedge clk)
    if (!rstn) begin
      o <= '{default: '0};
      out_valid <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1)
        for (int j = 0; j < 5; j++)
`ifdef PE_RELU_EN
          o[j] <= s[j][OUT_W-1] ? '0 : s[j];
`else
          o[j] <= s[j];
`endif
    end
  assign out_0 = o[0];
  assign out_1 = o[1];
  assign out_2 = o[2];
  assign out_3 = o[3];
  assign out_4 = o[4];
endmodule

// File: tb/tb_conv_pe_array.sv
// tb_conv_pe_array: randomized scoreboard bench for conv_pe_array against a plain-arithmetic convolution model
module tb_conv_pe_array;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn, data_valid, pe_valid, conv_done;
  logic [25:0] data;
  logic [6:0][23:0] pe;
  logic signed [21:0] o [5];
  logic out_valid, kernel_ready, drop_err;
  conv_pe_array dut (
    .clk(clk), .rstn(rstn), .data(data), .data_valid(data_valid),
    .pe_1(pe[0]), .pe_2(pe[1]), .pe_3(pe[2]), .pe_4(pe[3]), .pe_5(pe[4]), .pe_6(pe[5]), .pe_7(pe[6]),
    .pe_valid(pe_valid), .conv_done(conv_done),
    .out_0(o[0]), .out_1(o[1]), .out_2(o[2]), .out_3(o[3]), .out_4(o[4]),
    .out_valid(out_valid), .kernel_ready(kernel_ready), .drop_err(drop_err)
  );
  typedef struct {int exp; int v[5];} item_t;
  item_t q[$];
  int errs = 0, checks = 0, cyc = 0;
  int mw[3][3];
  int mb, ph;
  bit mdrop;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask
  function automatic logic [25:0] kw(int a, int b, int c);
    logic [7:0] x, y, z;
    x = a[7:0]; y = b[7:0]; z = c[7:0];
    return {2'b00, x, y, z};
  endfunction
  function automatic logic [25:0] bw(int b);
    logic [7:0] x;
    x = b[7:0];
    return {2'b01, 16'h0, x};
  endfunction
  function automatic logic [6:0][23:0] col(int base, int st);
    logic [6:0][23:0] p;
    for (int k = 0; k < 7; k++)
      for (int c = 0; c < 3; c++) begin
        int v;
        v = (base + (k*3 + c)*st) & 255;
        p[k][23-8*c -: 8] = v[7:0];
      end
    return p;
  endfunction
  function automatic int sx8(logic [7:0] b);
    return int'($signed(b));
  endfunction
  task automatic step(bit rn, bit dv, logic [25:0] d, bit pv, logic [6:0][23:0] p, bit cd);
    item_t it;
    bit wk, wb;
    rstn = rn; data_valid = dv; data = d; pe_valid = pv; pe = p; conv_done = cd;
    if (!rn) begin
      while (q.size() > 0 && q[$].exp > cyc) void'(q.pop_back());
      ph = 0; mb = 0; mdrop = 0;
      mw = '{default: 0};
    end else begin
      if (pv && ph == 4) begin
        it.exp = cyc + 2;
        for (int j = 0; j < 5; j++) begin
          int acc;
          acc = mb;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              acc += int'(p[j+r][23-8*c -: 8]) * mw[r][c];
`ifdef PE_RELU_EN
          if (acc < 0) acc = 0;
`endif
          it.v[j] = acc;
        end
        q.push_back(it);
      end else if (pv) mdrop = 1;
      wk = dv && d[25:24] == 2'b00;
      wb = dv && d[25:24] == 2'b01;
      if (wk) begin
        int row;
        row = (cd || ph == 0 || ph == 4) ? 0 : (ph == 1) ? 1 : 2;
        for (int c = 0; c < 3; c++) mw[row][c] = sx8(d[23-8*c -: 8]);
        ph = (row == 0) ? 1 : (row == 1) ? 2 : 3;
      end else if (cd) ph = 0;
      else if (wb && ph == 3) begin
        mb = sx8(d[7:0]);
        ph = 4;
      end
    end
    @(posedge clk);
    #1;
    chk("kernel_ready", int'(kernel_ready), int'(ph == 4));
    chk("drop_err", int'(drop_err), int'(mdrop));
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1, 0, '0, 0, '0, 0);
  endtask
  task automatic check_zero(string n);
    chk({n, "_out_valid"}, int'(out_valid), 0);
    for (int j = 0; j < 5; j++) chk({n, "_out"}, int'(o[j]), 0);
  endtask
  always @(negedge clk) begin
    item_t it;
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        it = q.pop_front();
        chk("latency", cyc, it.exp);
        for (int j = 0; j < 5; j++) chk($sformatf("out_%0d", j), int'(o[j]), it.v[j]);
      end
    end else if (q.size() > 0 && q[0].exp <= cyc) begin
      it = q.pop_front();
      checks++; errs++;
      $display("FAIL missing_out_valid: got 0 expected 1 for cycle %0d (cycle %0d)", it.exp, cyc);
    end
  end
  initial begin
    for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0, 0);
    check_zero("reset");
    idle(1);
    step(1, 1, kw(1, 0, 0), 0, '0, 0);
    step(1, 1, kw(0, 1, 0), 0, '0, 0);
    step(1, 1, kw(0, 0, 1), 0, '0, 0);
    step(1, 1, bw(5), 0, '0, 0);
    step(1, 0, '0, 1, col(10, 0), 0);
    idle(3);
    step(1, 1, kw(-1, -1, -1), 0, '0, 0);
    for (int i = 0; i < 2; i++) step(1, 1, kw(-1, -1, -1), 0, '0, 0);
    step(1, 1, bw(0), 0, '0, 0);
    step(1, 0, '0, 1, col(255, 0), 0);
    idle(3);
    step(1, 1, kw(2, -3, 4), 0, '0, 1);
    step(1, 0, '0, 1, col(7, 1), 0);
    step(1, 1, bw(9), 0, '0, 0);
    step(1, 1, kw(-5, 6, -7), 0, '0, 0);
    step(1, 1, kw(8, -9, 10), 0, '0, 0);
    step(1, 1, bw(-7), 0, '0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, '0, 1, col(i*40 + 3, i + 1), 0);
    idle(3);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] r;
      logic [1:0] tag;
      int t;
      r = $urandom();
      t = $urandom_range(0, 4);
      tag = (t < 2) ? 2'b00 : (t < 4) ? 2'b01 : {1'b1, r[31]};
      step(1, $urandom_range(0, 1) == 1, {tag, r[23:0]}, $urandom_range(0, 1) == 1,
           col($urandom_range(0, 255), $urandom_range(0, 255)), $urandom_range(0, 15) == 0);
    end
    idle(3);
    step(1, 1, kw(3, 1, -2), 0, '0, 1);
    step(1, 1, kw(-1, 4, 2), 0, '0, 0);
    step(1, 1, kw(5, -6, 1), 0, '0, 0);
    step(1, 1, bw(-100), 0, '0, 0);
    step(1, 0, '0, 1, col(200, 3), 0);
    step(0, 0, '0, 0, '0, 0);
    step(0, 0, '0, 0, '0, 0);
    check_zero("flush");
    idle(4);
    check_zero("after_flush");
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
